// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply, 32-step restoring divide.
// Build option MULDIV_DIV_EN adds the divider; without it divide ops finish at once with illegal=1.
module muldiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        illegal
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FINISH} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [63:0] acc_q, acc_d;       // product accumulator; low word carries fast-path results
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        fast_q, fast_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
`ifdef MULDIV_DIV_EN
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [32:0] dshift, ddiff;
  logic [31:0] dsel;
  logic        dsgn, ovf;
`endif
  logic        sa, sb;
  logic [32:0] msum;
  logic [63:0] prod;

  function automatic logic [31:0] cond_neg32(input logic n, input logic [31:0] x);
    return n ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic n, input logic [63:0] x);
    return n ? (~x + 64'd1) : x;
  endfunction

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    fast_d    = fast_q;
    result_d  = result_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    sa        = 1'b0;
    sb        = 1'b0;
    msum      = '0;
    prod      = '0;
`ifdef MULDIV_DIV_EN
    quo_d     = quo_q;
    rem_d     = rem_q;
    dshift    = '0;
    ddiff     = '0;
    dsel      = '0;
    dsgn      = 1'b0;
    ovf       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = funct3;
          cnt_d  = '0;
          fast_d = 1'b0;
          neg_d  = 1'b0;
          acc_d  = '0;
          if (!funct3[2]) begin
            sa      = ((funct3 == 3'b001) || (funct3 == 3'b010)) && operand_a[31];
            sb      = (funct3 == 3'b001) && operand_b[31];
            opnd_d  = cond_neg32(sa, operand_a);
            acc_d   = {32'd0, cond_neg32(sb, operand_b)};
            neg_d   = sa ^ sb;
            state_d = S_MUL;
          end else begin
`ifdef MULDIV_DIV_EN
            dsgn = !funct3[0];
            sa   = dsgn && operand_a[31];
            sb   = dsgn && operand_b[31];
            ovf  = dsgn && (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
            if (operand_b == 32'd0) begin
              fast_d  = 1'b1;
              acc_d   = {32'd0, funct3[1] ? operand_a : 32'hFFFF_FFFF};
              state_d = S_FINISH;
            end else if (ovf) begin
              fast_d  = 1'b1;
              acc_d   = {32'd0, funct3[1] ? 32'd0 : 32'h8000_0000};
              state_d = S_FINISH;
            end else begin
              opnd_d  = cond_neg32(sb, operand_b);
              quo_d   = cond_neg32(sa, operand_a);
              rem_d   = '0;
              // remainder takes the dividend's sign, quotient the xor of both
              neg_d   = funct3[1] ? sa : (sa ^ sb);
              state_d = S_DIV;
            end
`else
            fast_d  = 1'b1;
            state_d = S_FINISH;
`endif
          end
        end
      end
      S_MUL: begin
        msum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        acc_d = {msum, acc_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FINISH;
      end
`ifdef MULDIV_DIV_EN
      S_DIV: begin
        dshift = {rem_q, quo_q[31]};
        ddiff  = dshift - {1'b0, opnd_q};
        if (ddiff[32]) begin
          rem_d = dshift[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end else begin
          rem_d = ddiff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FINISH;
      end
`endif
      S_FINISH: begin
        if (fast_q) begin
          result_d = acc_q[31:0];
        end else if (!op_q[2]) begin
          prod     = cond_neg64(neg_q, acc_q);
          result_d = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
        end
`ifdef MULDIV_DIV_EN
        else begin
          dsel     = op_q[1] ? rem_q : quo_q;
          result_d = cond_neg32(neg_q, dsel);
        end
`else
        illegal_d = op_q[2];
`endif
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      fast_q    <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      quo_q     <= '0;
      rem_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      fast_q    <= fast_d;
      result_q  <= result_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
`ifdef MULDIV_DIV_EN
      quo_q     <= quo_d;
      rem_q     <= rem_d;
`endif
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign result  = result_q;
  assign illegal = illegal_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M vectors plus randomized ops checked every cycle
// against a 64-bit arithmetic model; follows MULDIV_DIV_EN to match the build under test.
module tb_muldiv_unit;
  logic        clock, reset, start;
  logic [2:0]  funct3;
  logic [31:0] operand_a, operand_b;
  logic        busy, done, illegal;
  logic [31:0] result;

  muldiv_unit dut (
    .clock(clock), .reset(reset), .start(start), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result), .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          e0;
    bit          lit_v;
    logic [31:0] lit;
  } op_t;
  op_t q[$];
  logic [31:0] last_res = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    pu = {32'd0, a} * {32'd0, b};
    p  = 0;
    case (f)
      3'd0: return pu[31:0];
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: return pu[63:32];
`ifdef MULDIV_DIV_EN
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa % sb;
        return p[31:0];
      end
      3'd7: return (b == 32'd0) ? a : a % b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_ill(input logic [2:0] f);
`ifdef MULDIV_DIV_EN
    return 1'b0 & f[2];
`else
    return f[2];
`endif
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 33;
`ifdef MULDIV_DIV_EN
    if (b == 32'd0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
`else
    return (a == b) ? 1 : 1;
`endif
  endfunction

  // compare process: every negedge the outputs are checked against the queued ops
  always @(negedge clock) begin
    op_t o;
    int  dc;
    logic [31:0] er;
    if (reset) begin
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      last_res = 32'd0;
    end else if (q.size() == 0) begin
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_illegal", {31'd0, illegal}, 32'd0);
      chk("idle_result", result, last_res);
    end else begin
      o  = q[0];
      dc = o.e0 + model_lat(o.f, o.a, o.b);
      if (cyc < o.e0) begin
        chk("pre_busy", {31'd0, busy}, 32'd0);
        chk("pre_done", {31'd0, done}, 32'd0);
      end else if (cyc < dc) begin
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("run_done", {31'd0, done}, 32'd0);
        chk("run_illegal", {31'd0, illegal}, 32'd0);
        chk("run_result_held", result, last_res);
      end else begin
        er = model_res(o.f, o.a, o.b);
        if (cyc > dc) chk("missing_done", 32'd0, 32'd1);
        chk("fin_done", {31'd0, done}, 32'd1);
        chk("fin_busy", {31'd0, busy}, 32'd0);
        chk("fin_result", result, er);
        chk("fin_illegal", {31'd0, illegal}, {31'd0, model_ill(o.f)});
        if (o.lit_v) chk("literal_result", result, o.lit);
        last_res = er;
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit lv, input logic [31:0] lit);
    op_t o;
    funct3    = f;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    o.f = f; o.a = a; o.b = b; o.e0 = cyc + 1; o.lit_v = lv; o.lit = lit;
    q.push_back(o);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clock);
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input bit lv, input logic [31:0] lit);
    issue(f, a, b, lv, lit);
    @(negedge clock);
    start = 1'b0;
    wait_done();
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; funct3 = 3'd0; operand_a = 32'd0; operand_b = 32'd0;
    repeat (3) @(negedge clock);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    chk("reset_result", result, 32'd0);
    #2 reset = 1'b0;
    @(negedge clock);

    run(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB);
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
`ifdef MULDIV_DIV_EN
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF);
    run(3'd5, 32'd100, 32'd7, 1'b1, 32'd14);
    run(3'd7, 32'd100, 32'd7, 1'b1, 32'd2);
    run(3'd5, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF);
    run(3'd6, 32'd5, 32'd0, 1'b1, 32'd5);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0);
`else
    run(3'd4, 32'd10, 32'd3, 1'b1, 32'd0);
    run(3'd0, 32'd3, 32'd4, 1'b1, 32'd12);
`endif

    // start pulsed mid-multiply with different operands must be ignored
    issue(3'd0, 32'd5, 32'd6, 1'b1, 32'd30);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    funct3 = 3'd3; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done();

    // back-to-back with start held high, then randomized traffic
    for (int i = 0; i < 80; i++) begin
      issue(3'($urandom_range(0, 7)), rand_word(), rand_word(), 1'b0, 32'd0);
      if ($urandom_range(0, 3) == 0) begin
        wait_done();
      end else begin
        @(negedge clock);
        start = 1'b0;
        wait_done();
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
    end
    start = 1'b0;
    run(3'd0, 32'd5, 32'd6, 1'b1, 32'd30);

    // reset in the middle of a multiply aborts it without a done
    issue(3'd0, 32'h1234, 32'h10, 1'b0, 32'd0);
    @(negedge clock);
    start = 1'b0;
    repeat (18) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    q.delete();
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (40) @(negedge clock);
    run(3'd0, 32'd3, 32'd4, 1'b1, 32'd12);
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
